// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file: MIPS register index
// constants, default widths, the read-source selector used by the optional
// forwarding path, and a helper that maps a debug tap slot to its register.
// Optional feature macro used by the files that import this package:
//   REGFILE_BYPASS_EN - forward same-cycle write data onto the read ports.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  localparam int NUM_TAPS = 4;

  // Where a read port takes its value from in a given cycle.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WP0   = 2'd1,
    SRC_WP1   = 2'd2
  } rd_src_e;

  // Debug tap slot -> architectural register: 0=$v0, 1=$a0, 2=$sp, 3=$ra.
  function automatic int tapIdx(input int slot);
    case (slot)
      0:       return REG_V0;
      1:       return REG_A0;
      2:       return REG_SP;
      default: return REG_RA;
    endcase
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bundle of the register file's write, scoreboard, read and debug signals.
//   master : pipeline side (drives writes, busy claims, read addresses)
//   slave  : register file side (returns read data, busy bits, debug taps)
// Signals:
//   we0/wa0/wd0     write port 0 (ALU writeback)
//   we1/wa1/wd1     write port 1 (load return)
//   busy_set/addr   claim a register for a pending producer
//   rd_addr         packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data         packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy         busy bit of each read address
//   dbg_v0/a0/sp/ra direct taps of registers 2, 4, 29, 31
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);

  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic                     busy_set;
  logic [ADDR_W-1:0]        busy_addr;
  logic [NREAD*ADDR_W-1:0]  rd_addr;
  logic [NREAD*DATA_W-1:0]  rd_data;
  logic [NREAD-1:0]         rd_busy;
  logic [DATA_W-1:0]        dbg_v0;
  logic [DATA_W-1:0]        dbg_a0;
  logic [DATA_W-1:0]        dbg_sp;
  logic [DATA_W-1:0]        dbg_ra;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, busy_set, busy_addr, rd_addr,
    input  rd_data, rd_busy, dbg_v0, dbg_a0, dbg_sp, dbg_ra
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, busy_set, busy_addr, rd_addr,
    output rd_data, rd_busy, dbg_v0, dbg_a0, dbg_sp, dbg_ra
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy bits used by the hazard unit. A register is claimed by
// busy_set and released by any accepted write to it. Register 0 never
// becomes busy and addresses at or above NREG are ignored.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   i_setEn, i_setAddr   claim request
//   i_clr0En, i_clr0Addr release from write port 0 (already qualified)
//   i_clr1En, i_clr1Addr release from write port 1 (already qualified)
//   i_lookupAddr         packed read addresses to look up
//   o_busy               busy bit per read port, from registered state
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREAD  = DEF_NREAD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_setEn,
  input  logic [ADDR_W-1:0]       i_setAddr,
  input  logic                    i_clr0En,
  input  logic [ADDR_W-1:0]       i_clr0Addr,
  input  logic                    i_clr1En,
  input  logic [ADDR_W-1:0]       i_clr1Addr,
  input  logic [NREAD*ADDR_W-1:0] i_lookupAddr,
  output logic [NREAD-1:0]        o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busyNext;

  // Clears are applied before the set so that a new producer claiming a
  // register on the same edge an older result lands keeps it busy. The
  // loop starts at 1, which keeps bit 0 permanently clear.
  always_comb begin
    w_busyNext = r_busy;
    w_busyNext[REG_ZERO] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (i_clr0En && (i_clr0Addr == ADDR_W'(i))) w_busyNext[i] = 1'b0;
      if (i_clr1En && (i_clr1Addr == ADDR_W'(i))) w_busyNext[i] = 1'b0;
      if (i_setEn && (i_setAddr == ADDR_W'(i)))   w_busyNext[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  // Per-port lookup; unmatched addresses (0 or out of range) read as idle.
  always_comb begin
    o_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      for (int i = 1; i < NREG; i++) begin
        if (i_lookupAddr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) o_busy[k] = r_busy[i];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port MIPS register file for the ID stage: NREAD combinational read
// ports, two synchronous write ports (port 0 = ALU writeback, port 1 = load
// return, port 0 wins a same-address collision), a busy scoreboard for the
// hazard unit and fixed debug taps for $v0, $a0, $sp and $ra.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data onto matching read ports (port 0 first) and to report such a read
// as not busy. Without it a consumer sees new data one cycle after the edge.
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset; registers 0 except $sp = SP_INIT
//   bus    regfile_mp_if slave modport carrying writes, claims, reads, taps
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              DATA_W  = DEF_DATA_W,
  parameter int              NREG    = DEF_NREG,
  parameter int              ADDR_W  = DEF_ADDR_W,
  parameter int              NREAD   = DEF_NREAD,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic          clk,
  input  logic          reset,
  regfile_mp_if.slave   bus
);

  localparam logic [ADDR_W:0] LP_NREG = (ADDR_W+1)'(NREG);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              w_wr0Ok;
  logic              w_wr1Ok;
  logic [NREAD-1:0]  w_sbBusy;
  logic [DATA_W-1:0] w_portData [NREAD];
  logic [NREAD-1:0]  w_portBusy;
  logic [DATA_W-1:0] w_tap [NUM_TAPS];

  // A write is accepted only for a real, in-range, non-zero register.
  assign w_wr0Ok = bus.we0 && (bus.wa0 != '0) && ({1'b0, bus.wa0} < LP_NREG);
  assign w_wr1Ok = bus.we1 && (bus.wa1 != '0) && ({1'b0, bus.wa1} < LP_NREG);

  // Register array. Entry 0 is only ever loaded by reset, so it stays zero.
  // Checking port 0 first drops port 1 on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_wr0Ok && (bus.wa0 == ADDR_W'(i))) begin
          r_regs[i] <= bus.wd0;
        end else if (w_wr1Ok && (bus.wa1 == ADDR_W'(i))) begin
          r_regs[i] <= bus.wd1;
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .i_setEn      (bus.busy_set),
    .i_setAddr    (bus.busy_addr),
    .i_clr0En     (w_wr0Ok),
    .i_clr0Addr   (bus.wa0),
    .i_clr1En     (w_wr1Ok),
    .i_clr1Addr   (bus.wa1),
    .i_lookupAddr (bus.rd_addr),
    .o_busy       (w_sbBusy)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_arrData;

    assign w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    // Address decode over valid entries only, so 0 and out-of-range
    // addresses fall through to zero.
    always_comb begin
      w_arrData = '0;
      for (int i = 1; i < NREG; i++) begin
        if (w_addr == ADDR_W'(i)) w_arrData = r_regs[i];
      end
    end

`ifdef REGFILE_BYPASS_EN
    rd_src_e w_src;

    // The qualified write enables already exclude register 0 and
    // out-of-range addresses, so a match here is always a real register.
    always_comb begin
      w_src = SRC_ARRAY;
      if (w_wr0Ok && (bus.wa0 == w_addr)) begin
        w_src = SRC_WP0;
      end else if (w_wr1Ok && (bus.wa1 == w_addr)) begin
        w_src = SRC_WP1;
      end
    end

    // A forwarded operand is ready this cycle, so it must not stall.
    always_comb begin
      w_portData[k] = w_arrData;
      w_portBusy[k] = w_sbBusy[k];
      case (w_src)
        SRC_WP0: begin
          w_portData[k] = bus.wd0;
          w_portBusy[k] = 1'b0;
        end
        SRC_WP1: begin
          w_portData[k] = bus.wd1;
          w_portBusy[k] = 1'b0;
        end
        default: ;
      endcase
    end
`else
    assign w_portData[k] = w_arrData;
    assign w_portBusy[k] = w_sbBusy[k];
`endif
  end

  // Pack the per-port results onto the bus in one place.
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NREAD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = w_portData[k];
    end
  end

  assign bus.rd_busy = w_portBusy;

  // Debug taps look straight at the array; a tap whose register does not
  // exist in a reduced configuration reads as zero.
  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    if (tapIdx(t) < NREG) begin : g_present
      assign w_tap[t] = r_regs[tapIdx(t)];
    end else begin : g_absent
      assign w_tap[t] = '0;
    end
  end

  assign bus.dbg_v0 = w_tap[0];
  assign bus.dbg_a0 = w_tap[1];
  assign bus.dbg_sp = w_tap[2];
  assign bus.dbg_ra = w_tap[3];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Self-checking bench for regfile_mp (default parameters, SP_INIT=32'h3FFC).
// A reference model holds the register contents and busy flags as plain
// arrays, updated from the architectural rules at every rising edge.
// Outputs are sampled mid-cycle, well away from the rising edge.
module tb_regfile_mp;

  localparam logic [31:0] SP_VAL = 32'h0000_3FFC;

  logic clk;
  logic reset;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();

  regfile_mp #(
    .DATA_W  (32),
    .NREG    (32),
    .ADDR_W  (5),
    .NREAD   (2),
    .SP_INIT (SP_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mRegs [32];
  bit          mBusy [32];

  // Expected read value under the current (not yet committed) inputs.
  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we0 && bus.wa0 == a) return bus.wd0;
    if (bus.we1 && bus.wa1 == a) return bus.wd1;
`endif
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((bus.we0 && bus.wa0 == a) || (bus.we1 && bus.wa1 == a)) return 1'b0;
`endif
    return mBusy[a];
  endfunction

  // Architectural effect of one rising edge.
  task automatic commit();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mRegs[i] = 32'h0;
        mBusy[i] = 1'b0;
      end
      mRegs[29] = SP_VAL;
    end else begin
      if (bus.we1 && bus.wa1 != 0 && !(bus.we0 && bus.wa0 == bus.wa1)) mRegs[bus.wa1] = bus.wd1;
      if (bus.we0 && bus.wa0 != 0) mRegs[bus.wa0] = bus.wd0;
      if (bus.we0 && bus.wa0 != 0) mBusy[bus.wa0] = 1'b0;
      if (bus.we1 && bus.wa1 != 0) mBusy[bus.wa1] = 1'b0;
      if (bus.busy_set && bus.busy_addr != 0) mBusy[bus.busy_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #2;
  endtask

  task automatic applyStimulus(input bit we0, input logic [4:0] wa0, input logic [31:0] wd0,
                               input bit we1, input logic [4:0] wa1, input logic [31:0] wd1,
                               input bit bset, input logic [4:0] baddr,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    bus.we0 = we0; bus.wa0 = wa0; bus.wd0 = wd0;
    bus.we1 = we1; bus.wa1 = wa1; bus.wd1 = wd1;
    bus.busy_set = bset; bus.busy_addr = baddr;
    bus.rd_addr = {ra1, ra0};
    #1;
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, ra0, ra1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1, 5'd6, 32'h1234_5678, 1, 5'd7, 32'h8765_4321, 1, 5'd6, 5'd1, 5'd6);
    tick();
    tick();
    reset = 1'b0;
    idle(5'd6, 5'd7);
    vectors++;
    if (bus.dbg_sp !== SP_VAL) begin
      miscompares++;
      $display("[TB] FAIL reset_dbg_sp: got %h expected %h", bus.dbg_sp, SP_VAL);
    end
    vectors++;
    if ({bus.dbg_v0, bus.dbg_a0, bus.dbg_ra} !== 96'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_dbg_taps: got %h %h %h expected 0", bus.dbg_v0, bus.dbg_a0, bus.dbg_ra);
    end
    vectors++;
    if (bus.rd_data !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
    vectors++;
    if (bus.rd_busy !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_busy: got %b expected 00", bus.rd_busy);
    end
  endtask

  task automatic test_write();
    applyStimulus(1, 5'd8, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 0, 5'd0, 5'd8, 5'd0);
    tick();
    idle(5'd8, 5'd0);
    vectors++;
    if (bus.rd_data[31:0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("[TB] FAIL write_reg8: got %h expected %h", bus.rd_data[31:0], 32'hDEAD_BEEF);
    end
    applyStimulus(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hEEEE_EEEE, 0, 5'd0, 5'd0, 5'd0);
    vectors++;
    if (bus.rd_data !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL write_reg0_same_cycle: got %h expected 0", bus.rd_data);
    end
    tick();
    idle(5'd0, 5'd0);
    vectors++;
    if (bus.rd_data !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL write_reg0: got %h expected 0", bus.rd_data);
    end
  endtask

  task automatic test_collision();
    applyStimulus(1, 5'd5, 32'h1, 1, 5'd5, 32'h2, 0, 5'd0, 5'd5, 5'd5);
    tick();
    idle(5'd5, 5'd5);
    vectors++;
    if (bus.rd_data !== {32'h1, 32'h1}) begin
      miscompares++;
      $display("[TB] FAIL collision_reg5: got %h expected %h", bus.rd_data, {32'h1, 32'h1});
    end
  endtask

  task automatic test_scoreboard();
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd9);
    vectors++;
    if (bus.rd_busy[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_before_edge: got %b expected 0", bus.rd_busy[1]);
    end
    tick();
    idle(5'd9, 5'd9);
    vectors++;
    if (bus.rd_busy !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL busy_set_reg9: got %b expected 11", bus.rd_busy);
    end
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd0);
    tick();
    idle(5'd9, 5'd0);
    vectors++;
    if (bus.rd_busy[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_clear_reg9: got %b expected 0", bus.rd_busy[0]);
    end
    applyStimulus(1, 5'd9, 32'h9A, 0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd9);
    vectors++;
    if (bus.rd_busy[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_set_wins: got %b expected 1", bus.rd_busy[1]);
    end
    vectors++;
    if (bus.rd_data[63:32] !== 32'h9A) begin
      miscompares++;
      $display("[TB] FAIL busy_set_wins_data: got %h expected %h", bus.rd_data[63:32], 32'h9A);
    end
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    vectors++;
    if (bus.rd_busy !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL busy_reg0: got %b expected 00", bus.rd_busy);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] expData;
    logic        expB;
    applyStimulus(1, 5'd12, 32'h1111_2222, 0, 5'd0, 32'h0, 1, 5'd12, 5'd0, 5'd0);
    tick();
    applyStimulus(1, 5'd12, 32'hA5A5_A5A5, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd12);
`ifdef REGFILE_BYPASS_EN
    expData = 32'hA5A5_A5A5;
    expB    = 1'b0;
`else
    expData = 32'h1111_2222;
    expB    = 1'b1;
`endif
    vectors++;
    if (bus.rd_data[63:32] !== expData) begin
      miscompares++;
      $display("[TB] FAIL bypass_data: got %h expected %h", bus.rd_data[63:32], expData);
    end
    vectors++;
    if (bus.rd_busy[1] !== expB) begin
      miscompares++;
      $display("[TB] FAIL bypass_busy: got %b expected %b", bus.rd_busy[1], expB);
    end
    tick();
    idle(5'd0, 5'd12);
    vectors++;
    if (bus.rd_data[63:32] !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("[TB] FAIL bypass_after: got %h expected %h", bus.rd_data[63:32], 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      if (i % 2 == 0) applyStimulus(1, 5'd2, v, 0, 5'd0, 32'h0, 0, 5'd0, 5'd2, 5'd2);
      else            applyStimulus(0, 5'd0, 32'h0, 1, 5'd2, v, 0, 5'd0, 5'd2, 5'd2);
      tick();
      idle(5'd2, 5'd2);
      vectors++;
      if (bus.dbg_v0 !== v || bus.rd_data[31:0] !== v) begin
        miscompares++;
        $display("[TB] FAIL back_to_back_%0d: got %h/%h expected %h", i, bus.dbg_v0, bus.rd_data[31:0], v);
      end
    end
  endtask

  task automatic test_midreset();
    applyStimulus(1, 5'd3, 32'h7, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1, 5'd3, 32'h7, 1, 5'd4, 32'h44, 1, 5'd3, 5'd3, 5'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(5'd3, 5'd4);
    vectors++;
    if (bus.rd_data !== 64'h0 || bus.dbg_a0 !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_reg3: got %h a0 %h expected 0", bus.rd_data, bus.dbg_a0);
    end
    vectors++;
    if (bus.rd_busy !== 2'b00 || bus.dbg_sp !== SP_VAL) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got busy %b sp %h expected 00 %h", bus.rd_busy, bus.dbg_sp, SP_VAL);
    end
  endtask

  task automatic test_random();
    logic [4:0]  ra;
    logic [31:0] dbgExp [4];
    logic [31:0] dbgGot [4];
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(39, 0) == 0);
      applyStimulus($urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)), $urandom,
                    $urandom_range(1, 0) == 1, 5'($urandom_range(31, 0)), $urandom,
                    $urandom_range(2, 0) == 0, 5'($urandom_range(31, 0)),
                    5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
      for (int k = 0; k < 2; k++) begin
        ra = bus.rd_addr[k*5 +: 5];
        vectors++;
        if (bus.rd_data[k*32 +: 32] !== expRead(ra)) begin
          miscompares++;
          $display("[TB] FAIL random_data[%0d] n=%0d addr=%0d: got %h expected %h",
                   k, n, ra, bus.rd_data[k*32 +: 32], expRead(ra));
        end
        vectors++;
        if (bus.rd_busy[k] !== expBusy(ra)) begin
          miscompares++;
          $display("[TB] FAIL random_busy[%0d] n=%0d addr=%0d: got %b expected %b",
                   k, n, ra, bus.rd_busy[k], expBusy(ra));
        end
      end
      dbgExp = '{mRegs[2], mRegs[4], mRegs[29], mRegs[31]};
      dbgGot = '{bus.dbg_v0, bus.dbg_a0, bus.dbg_sp, bus.dbg_ra};
      for (int t = 0; t < 4; t++) begin
        vectors++;
        if (dbgGot[t] !== dbgExp[t]) begin
          miscompares++;
          $display("[TB] FAIL random_dbg[%0d] n=%0d: got %h expected %h", t, n, dbgGot[t], dbgExp[t]);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle(5'd0, 5'd0);
    test_reset();
    test_write();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
